// File: rtl/led_blinker_pkg.sv
// Shared defaults and parameter-legality helper for the LED blinker.
package led_blinker_pkg;

    localparam int LED_CNT_W_DEF       = 4;
    localparam int LED_HALF_PERIOD_DEF = 8;
    localparam int LED_PRESCALE_DEF    = 1;

    function automatic logic led_params_ok(input int cnt_w, input int half_period, input int prescale);
        longint max_half;
        max_half = longint'(1) << cnt_w;
        if ((half_period < 1) || (longint'(half_period) > max_half) || (prescale < 1) || (cnt_w < 1)) begin
            return 1'b0;
        end else begin
            return 1'b1;
        end
    endfunction

endpackage

// File: rtl/led_blinker_prescaler.sv
// Tick prescaler: tick is high in the clock where pre reaches PRESCALE-1.
module led_blinker_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    // A single-bit counter pinned at 0 makes tick constant high for PRESCALE = 1.
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_d;
    logic [PRE_W-1:0] pre_q;

    // Next prescaler value with wrap at PRESCALE-1.
    always_comb begin
        pre_d = pre_q;
        if (pre_q == PRE_LAST) begin
            pre_d = {PRE_W{1'b0}};
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    // Prescaler state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= {PRE_W{1'b0}};
        end else begin
            pre_q <= pre_d;
        end
    end

    assign tick = (pre_q == PRE_LAST);

endmodule

// File: rtl/led_blinker_core.sv
// Free-running 50% duty LED blinker. Define LED_BLINKER_CNT_OUT_EN to expose
// the half-period counter on the count port.
module led_blinker_core
    import led_blinker_pkg::*;
#(
    parameter int CNT_W       = LED_CNT_W_DEF,
    parameter int HALF_PERIOD = LED_HALF_PERIOD_DEF,
    parameter int PRESCALE    = LED_PRESCALE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic             led
`ifdef LED_BLINKER_CNT_OUT_EN
    ,
    output logic [CNT_W-1:0] count
`endif
);

    if (!led_params_ok(CNT_W, HALF_PERIOD, PRESCALE)) begin : g_bad_params
        $fatal(1, "led_blinker_core: illegal CNT_W/HALF_PERIOD/PRESCALE");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

    logic             tick;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             led_d;
    logic             led_q;

    led_blinker_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Half-period compare: wrap cnt and flip led together on the last tick of a phase.
    always_comb begin
        cnt_d = cnt_q;
        led_d = led_q;
        if (tick) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = {CNT_W{1'b0}};
                led_d = ~led_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                led_d = led_q;
            end
        end else begin
            cnt_d = cnt_q;
            led_d = led_q;
        end
    end

    // Counter and LED registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {CNT_W{1'b0}};
            led_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            led_q <= led_d;
        end
    end

    assign led = led_q;
`ifdef LED_BLINKER_CNT_OUT_EN
    assign count = cnt_q;
`endif

endmodule

// File: tb/tb_led_blinker_core.sv
// Directed bench for led_blinker_core over four parameter sets sharing one clock/reset.
module tb_led_blinker_core;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   edges;

    logic       led0, led1, led2, led3;
`ifdef LED_BLINKER_CNT_OUT_EN
    logic [3:0] cnt0, cnt1, cnt2;
    logic [1:0] cnt3;
`endif

    led_blinker_core u_d0 (
        .clk (clk), .rst (rst), .led (led0)
`ifdef LED_BLINKER_CNT_OUT_EN
        , .count (cnt0)
`endif
    );
    led_blinker_core #(.CNT_W(4), .HALF_PERIOD(1), .PRESCALE(1)) u_d1 (
        .clk (clk), .rst (rst), .led (led1)
`ifdef LED_BLINKER_CNT_OUT_EN
        , .count (cnt1)
`endif
    );
    led_blinker_core #(.CNT_W(4), .HALF_PERIOD(16), .PRESCALE(1)) u_d2 (
        .clk (clk), .rst (rst), .led (led2)
`ifdef LED_BLINKER_CNT_OUT_EN
        , .count (cnt2)
`endif
    );
    led_blinker_core #(.CNT_W(2), .HALF_PERIOD(2), .PRESCALE(3)) u_d3 (
        .clk (clk), .rst (rst), .led (led3)
`ifdef LED_BLINKER_CNT_OUT_EN
        , .count (cnt3)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_led(input int n, input int hp, input int ps);
        return 32'((n / ps / hp) % 2);
    endfunction

    function automatic logic [31:0] exp_cnt(input int n, input int hp, input int ps);
        return 32'((n / ps) % hp);
    endfunction

    task automatic check_all(input int n);
        check($sformatf("d0.led@%0d", n), 32'(led0), exp_led(n, 8, 1));
        check($sformatf("d1.led@%0d", n), 32'(led1), exp_led(n, 1, 1));
        check($sformatf("d2.led@%0d", n), 32'(led2), exp_led(n, 16, 1));
        check($sformatf("d3.led@%0d", n), 32'(led3), exp_led(n, 2, 3));
`ifdef LED_BLINKER_CNT_OUT_EN
        check($sformatf("d0.cnt@%0d", n), 32'(cnt0), exp_cnt(n, 8, 1));
        check($sformatf("d1.cnt@%0d", n), 32'(cnt1), exp_cnt(n, 1, 1));
        check($sformatf("d2.cnt@%0d", n), 32'(cnt2), exp_cnt(n, 16, 1));
        check($sformatf("d3.cnt@%0d", n), 32'(cnt3), exp_cnt(n, 2, 3));
`endif
    endtask

    // Advance n rising edges, checking every instance on each following falling edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            check_all(edges);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        edges  = 0;
        rst    = 1'b0;

        // Reset hold: ~60 ns with rst low, everything stays 0.
        #1;
        check_all(0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_all(0);
        end

        // Release between edges; next posedge is edge 1.
        rst = 1'b1;
        run(40);

        // Restart, run into the high phase of the default instance, then reset asynchronously.
        rst = 1'b0;
        #1;
        rst = 1'b1;
        edges = 0;
        run(10);
        check("d0.led_high_before_rst", 32'(led0), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check_all(0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_all(0);
        end

        rst = 1'b1;
        edges = 0;
        run(7);
        check("d0.no_rise_by_edge7", 32'(led0), 32'd0);
        run(1);
        check("d0.rise_at_edge8", 32'(led0), 32'd1);
        run(24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
